// File: rtl/brc_seq_ctrl.sv
// brc_seq_ctrl - multi-cycle branch-resolution controller.
//
// Accepts a branch request (funct3, rs1, rs2) on a valid/ready handshake,
// walks a CHUNK-bit comparator from the MSB chunk down to the LSB chunk
// (stopping at the first chunk that differs) and returns less/equal/taken
// on a second valid/ready handshake.
//
// Ports:
//   i_clk, i_rst              clock (rising edge), synchronous active-high reset
//   i_req_valid, o_req_ready  request handshake
//   i_funct3                  branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   i_rs1_data, i_rs2_data    operands A and B
//   o_rsp_valid, i_rsp_ready  response handshake
//   o_brc_less, o_brc_equal   compare result (signedness from funct3[1])
//   o_taken                   branch decision
//   o_illegal                 funct3 was 010/011
//   o_busy                    controller not idle
module brc_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic            o_brc_less,
  output logic            o_brc_equal,
  output logic            o_taken,
  output logic            o_illegal,
  output logic            o_busy
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              br_un_q, br_un_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              less_q, less_d;
  logic              equal_q, equal_d;
  logic              taken_q, taken_d;
  logic              illegal_q, illegal_d;

  // Operands viewed as an array of chunks so the active chunk is a plain index.
  logic [NCHUNK-1:0][CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK-1:0]             ca, cb;

  assign a_ch = rs1_q;
  assign b_ch = rs2_q;

  function automatic logic taken_f(input logic [2:0] f, input logic l, input logic e);
    case (f)
      3'b000:          taken_f = e;
      3'b001:          taken_f = ~e;
      3'b100, 3'b110:  taken_f = l;
      3'b101, 3'b111:  taken_f = ~l;
      default:         taken_f = 1'b0;
    endcase
  endfunction

  // Current chunk pair. For signed compares the top chunk's sign bits are
  // flipped so that an unsigned compare of the biased values gives the
  // signed ordering; lower chunks are always unsigned magnitudes.
  always_comb begin
    ca = a_ch[idx_q];
    cb = b_ch[idx_q];
    if (idx_q == IDX_TOP && !br_un_q) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    funct3_d    = funct3_q;
    br_un_d     = br_un_q;
    rsp_valid_d = rsp_valid_q;
    less_d      = less_q;
    equal_d     = equal_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          rs1_d    = i_rs1_data;
          rs2_d    = i_rs2_data;
          funct3_d = i_funct3;
          br_un_d  = i_funct3[1];
          idx_d    = IDX_TOP;
          if (i_funct3[2:1] == 2'b01) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            illegal_d   = 1'b1;
            less_d      = 1'b0;
            equal_d     = 1'b0;
            taken_d     = 1'b0;
          end else begin
            state_d = S_CMP;
          end
        end
      end
      S_CMP: begin
        if (ca != cb || idx_q == '0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          illegal_d   = 1'b0;
          less_d      = (ca < cb);
          equal_d     = (ca == cb);
          taken_d     = taken_f(funct3_q, ca < cb, ca == cb);
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= IDX_TOP;
      rs1_q       <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      br_un_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      less_q      <= 1'b0;
      equal_q     <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      funct3_q    <= funct3_d;
      br_un_q     <= br_un_d;
      rsp_valid_q <= rsp_valid_d;
      less_q      <= less_d;
      equal_q     <= equal_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
    end
  end

  // Ready/busy are forced low while reset is asserted.
  assign o_req_ready = (state_q == S_IDLE) && !i_rst;
  assign o_busy      = (state_q != S_IDLE) && !i_rst;
  assign o_rsp_valid = rsp_valid_q;
  assign o_brc_less  = less_q;
  assign o_brc_equal = equal_q;
  assign o_taken     = taken_q;
  assign o_illegal   = illegal_q;

endmodule
